mul_unit: RTL

Two-stage pipelined RV64M multiply execution unit. Accepts decoded MUL/MULH/MULHSU/MULHU/MULW operations from the issue stage over a valid/ready handshake and drives the operand register feeding the `mult64` array. It selects and sign-corrects the 128-bit product into the 64-bit writeback result, then presents that result downstream with a valid/ready handshake and an rd tag passthrough.

---
 rtl/mul_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mul_unit.sv
// mul_unit: two-stage pipelined RV64M multiply unit (MUL/MULH/MULHSU/MULHU/MULW).
// S1 registers operands into mult64; S2 registers the selected 64-bit result.

module mult64 (
  input  logic [63:0]  a,
  input  logic [63:0]  b,
  input  logic         is_signed,
  output logic [127:0] p
);

  logic [127:0] ea;
  logic [127:0] eb;

  // Sign- or zero-extend to 128 bits; the product modulo 2^128 is exact.
  always_comb begin
    ea = {{64{is_signed & a[63]}}, a};
    eb = {{64{is_signed & b[63]}}, b};
    p  = ea * eb;
  end

endmodule

module mul_unit #(
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic             in_is_word,
  input  logic [63:0]      in_src1,
  input  logic [63:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    OP_MUL,
    OP_MULH,
    OP_MULHSU,
    OP_MULHU,
    OP_MULW
  } op_e;

  op_e              in_op;
  op_e              s1_op;
  logic             s1_valid;
  logic [63:0]      s1_src1;
  logic [63:0]      s1_src2;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [63:0]      s2_result;
  logic [TAG_W-1:0] s2_tag;

  logic             s1_load;
  logic             s2_load;
  logic             mul_signed;
  logic [127:0]     prod;
  logic [63:0]      result;
  logic             unused_funct3;

  assign unused_funct3 = in_funct3[2];

  // Handshake and stage-advance control.
  always_comb begin
    s2_load  = s1_valid & (~s2_valid | out_ready);
    in_ready = ~flush & (~s1_valid | s2_load);
    s1_load  = in_valid & in_ready;
  end

  // Decode the issue-stage op; the word form overrides funct3.
  always_comb begin
    in_op = OP_MUL;
    if (in_is_word) begin
      in_op = OP_MULW;
    end else begin
      case (in_funct3[1:0])
        2'b00:   in_op = OP_MUL;
        2'b01:   in_op = OP_MULH;
        2'b10:   in_op = OP_MULHSU;
        default: in_op = OP_MULHU;
      endcase
    end
  end

  // S1 operand register.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_MUL;
      s1_src1  <= '0;
      s1_src2  <= '0;
      s1_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_op    <= in_op;
      s1_src1  <= in_src1;
      s1_src2  <= in_src2;
      s1_tag   <= in_tag;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  assign mul_signed = (s1_op == OP_MULH);

  mult64 u_mult (
    .a         (s1_src1),
    .b         (s1_src2),
    .is_signed (mul_signed),
    .p         (prod)
  );

  // Select and sign-correct the product; MULHSU fixes up the unsigned high half.
  always_comb begin
    result = prod[63:0];
    unique case (s1_op)
      OP_MUL:    result = prod[63:0];
      OP_MULH:   result = prod[127:64];
      OP_MULHU:  result = prod[127:64];
      OP_MULHSU: result = prod[127:64]
                        - (s1_src1[63] ? s1_src2 : 64'd0);
      OP_MULW:   result = {{32{prod[31]}}, prod[31:0]};
      default:   result = prod[63:0];
    endcase
  end

  // S2 result register; holds while stalled, drops valid when drained.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_tag    <= '0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_load) begin
      s2_valid  <= 1'b1;
      s2_result <= result;
      s2_tag    <= s1_tag;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_tag    = s2_tag;

endmodule
